// File: rtl/dccm_lsu_ctrl_if.sv
// dccm_lsu_ctrl_if: core request/response and DCCM bus bundle.
// slave = controller side, master = core plus DCCM macro side.
interface dccm_lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dccm_wren;
  logic              dccm_rden;
  logic [ADDR_W-1:0] dccm_wr_addr;
  logic [31:0]       dccm_wr_data;
  logic [31:0]       dccm_rd_data;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  dccm_rd_data,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, dccm_wren, dccm_rden,
    output dccm_wr_addr, dccm_wr_data
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output dccm_rd_data,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, dccm_wren, dccm_rden,
    input  dccm_wr_addr, dccm_wr_data
  );
endinterface

// File: rtl/dccm_lsu_ctrl.sv
// dccm_lsu_ctrl: DCCM load/store controller, sub-word stores via RMW.
// DCCM_LSU_MISALIGN_TRAP_EN: misaligned -> error, else address is aligned down.
module dccm_lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  dccm_lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_RSP, RMW_RD,
    RMW_MRG, ST_WR, ST_RSP, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wd_q, wd_d;

  logic              mis;
  logic [ADDR_W-1:0] acc_addr;
  logic [4:0]        sh;
  logic [31:0]       rsh, ld, mask, merged;

  // Alignment handling of the incoming request address.
  always_comb begin
    mis      = 1'b0;
    acc_addr = bus.req_addr;
`ifdef DCCM_LSU_MISALIGN_TRAP_EN
    mis = (bus.req_size == 2'b01 && bus.req_addr[0])
        | (bus.req_size[1] && |bus.req_addr[1:0]);
`else
    unique case (1'b1)
      bus.req_size[1]:
        acc_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
      bus.req_size == 2'b01:
        acc_addr = {bus.req_addr[ADDR_W-1:1], 1'b0};
      default: acc_addr = bus.req_addr;
    endcase
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    sh   = {addr_q[1:0], 3'b000};
    rsh  = bus.dccm_rd_data >> sh;
    ld   = bus.dccm_rd_data;
    mask = 32'hFFFF_FFFF;
    if (size_q == 2'b00) begin
      ld   = uns_q ? {24'b0, rsh[7:0]}
                   : {{24{rsh[7]}}, rsh[7:0]};
      mask = 32'h0000_00FF << sh;
    end else if (size_q == 2'b01) begin
      ld   = uns_q ? {16'b0, rsh[15:0]}
                   : {{16{rsh[15]}}, rsh[15:0]};
      mask = 32'h0000_FFFF << sh;
    end
    merged = (bus.dccm_rd_data & ~mask)
           | ((wd_q << sh) & mask);
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    size_d         = size_q;
    uns_d          = uns_q;
    wd_d           = wd_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'b0;
    bus.resp_err   = 1'b0;
    bus.dccm_wren  = 1'b0;
    bus.dccm_rden  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d = acc_addr;
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          if (bus.req_we) wd_d = bus.req_wdata;
          if (mis)              state_d = ERR;
          else if (!bus.req_we) state_d = LD_RD;
          else if (bus.req_size[1]) state_d = ST_WR;
          else                  state_d = RMW_RD;
        end
      end
      LD_RD: begin
        bus.dccm_rden = 1'b1;
        state_d       = LD_RSP;
      end
      LD_RSP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = ld;
        state_d        = IDLE;
      end
      RMW_RD: begin
        bus.dccm_rden = 1'b1;
        state_d       = RMW_MRG;
      end
      RMW_MRG: begin
        wd_d    = merged;
        state_d = ST_WR;
      end
      ST_WR: begin
        bus.dccm_wren = 1'b1;
        state_d       = ST_RSP;
      end
      ST_RSP: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
`ifdef DCCM_LSU_MISALIGN_TRAP_EN
        bus.resp_err   = 1'b1;
`endif
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'b0;
      bus.resp_err   = 1'b0;
      bus.dccm_wren  = 1'b0;
      bus.dccm_rden  = 1'b0;
    end
  end

  assign bus.dccm_wr_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.dccm_wr_data = wd_q;

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wd_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_dccm_lsu_ctrl.sv
// tb_dccm_lsu_ctrl: directed stimulus with response/write scoreboards.
// Expectations follow DCCM_LSU_MISALIGN_TRAP_EN when it is defined.
module tb_dccm_lsu_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dccm_lsu_ctrl_if #(.ADDR_W(32)) bus();

  dccm_lsu_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          due;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  logic [31:0] mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.dccm_wren)
      mem[bus.dccm_wr_addr[11:2]] <= bus.dccm_wr_data;
    if (bus.dccm_rden)
      bus.dccm_rd_data <= mem[bus.dccm_wr_addr[11:2]];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (bus.resp_valid) begin
      if (rq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rsp_unexp: got resp at %0d want none", cyc);
      end else begin
        r = rq.pop_front();
        chk("rsp_data", bus.resp_rdata, r.d);
        chk("rsp_err", {31'b0, bus.resp_err}, {31'b0, r.e});
        chk("rsp_cyc", cyc, r.due);
      end
    end else if (rq.size() > 0 && cyc > rq[0].due) begin
      r = rq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL rsp_timeout: got none want resp at %0d", r.due);
    end
    if (bus.dccm_wren) begin
      if (wq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL wr_unexp: got write %h at %0d want none",
                 bus.dccm_wr_data, cyc);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", bus.dccm_wr_addr, w.a);
        chk("wr_data", bus.dccm_wr_data, w.d);
        chk("wr_cyc", cyc, w.due);
      end
    end else if (wq.size() > 0 && cyc > wq[0].due) begin
      w = wq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL wr_timeout: got none want write at %0d", w.due);
    end
    if (bus.dccm_wren || bus.dccm_rden)
      chk("strobe_excl",
          {31'b0, bus.dccm_wren & bus.dccm_rden}, 32'b0);
  end

  function automatic void exp_r(input int due,
                                input logic [31:0] d,
                                input logic e);
    rsp_t r;
    r.d = d;
    r.e = e;
    r.due = due;
    rq.push_back(r);
  endfunction

  function automatic void exp_w(input int due,
                                input logic [31:0] a,
                                input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    w.due = due;
    wq.push_back(w);
  endfunction

  task automatic preload(input logic [31:0] a,
                         input logic [31:0] v);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = a[11:2];
    pre_val = v;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic issue(input logic we,
                       input logic [1:0] sz,
                       input logic un,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input bit hold,
                       output int acc);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got ready=0 want ready=1");
      bus.req_valid = 1'b0;
      acc = -100;
    end else begin
      acc = cyc;
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (rq.size() == 0 && wq.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a1;
    int a2;
    rst              = 1'b1;
    pre_en           = 1'b0;
    pre_idx          = '0;
    pre_val          = '0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_rerr", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_wren", {31'b0, bus.dccm_wren}, 32'd0);
    chk("rst_rden", {31'b0, bus.dccm_rden}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_waddr", bus.dccm_wr_addr, 32'd0);
    chk("rst_wdata", bus.dccm_wr_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, a1);
    exp_w(a1 + 1, 32'h100, 32'hDEADBEEF);
    exp_r(a1 + 2, 32'h0, 1'b0);
    drain();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'hDEADBEEF, 1'b0);
    drain();
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'hDEADBEEF, 1'b0);
    drain();

    preload(32'h200, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'hFFFFFF80, 1'b0);
    drain();
    issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'h00000080, 1'b0);
    drain();
    issue(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'h0000007F, 1'b0);
    drain();
    issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'h000080FF, 1'b0);
    drain();
    issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'hFFFF80FF, 1'b0);
    drain();

    preload(32'h300, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h301, 32'h123456AA, 1'b0, a1);
    exp_w(a1 + 3, 32'h300, 32'h1122AA44);
    exp_r(a1 + 4, 32'h0, 1'b0);
    drain();
    preload(32'h300, 32'h11223344);
    issue(1'b1, 2'b01, 1'b0, 32'h302, 32'hFFFFBEEF, 1'b0, a1);
    exp_w(a1 + 3, 32'h300, 32'hBEEF3344);
    exp_r(a1 + 4, 32'h0, 1'b0);
    drain();
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, a1);
    exp_r(a1 + 2, 32'hBEEF3344, 1'b0);
    drain();

    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, a1);
`ifdef DCCM_LSU_MISALIGN_TRAP_EN
    exp_r(a1 + 1, 32'h0, 1'b1);
`else
    exp_r(a1 + 2, 32'hDEADBEEF, 1'b0);
`endif
    drain();
    issue(1'b1, 2'b01, 1'b0, 32'h301, 32'h00005555, 1'b0, a1);
`ifdef DCCM_LSU_MISALIGN_TRAP_EN
    exp_r(a1 + 1, 32'h0, 1'b1);
`else
    exp_w(a1 + 3, 32'h300, 32'hBEEF5555);
    exp_r(a1 + 4, 32'h0, 1'b0);
`endif
    drain();
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, a1);
`ifdef DCCM_LSU_MISALIGN_TRAP_EN
    exp_r(a1 + 2, 32'hBEEF3344, 1'b0);
`else
    exp_r(a1 + 2, 32'hBEEF5555, 1'b0);
`endif
    drain();

    preload(32'h300, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AA, 1'b0, a1);
    for (int i = 0; i < 10 && cyc < a1 + 2; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wren", {31'b0, bus.dccm_wren}, 32'd0);
    chk("rst_mid_rden", {31'b0, bus.dccm_rden}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_mid_mem", mem[192], 32'h11223344);

    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, a1);
    exp_r(a1 + 2, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, a2);
    exp_r(a2 + 2, 32'h80FF7F01, 1'b0);
    chk("b2b_gap", a2 - a1, 32'd3);
    drain();

    if (rq.size() != 0 || wq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               rq.size(), wq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
